// File: rtl/cpu57_selftest_seq_if.sv
// Bus bundle between the cpu57 self-test sequencer and its surroundings.
// CPU57_SELFTEST_IO_CHECK_EN adds the io readback pair.
interface cpu57_selftest_seq_if #(
  parameter int DATA_W = 57,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [15:0]       fail_mask;
  logic [CNT_W-1:0]  cycle_count;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst_n;
  logic              cpu_halted;
  logic [3:0]        reg_sel;
  logic [DATA_W-1:0] reg_data;
  logic [3:0]        exp_sel;
  logic [DATA_W-1:0] exp_data;
`ifdef CPU57_SELFTEST_IO_CHECK_EN
  logic [3:0]        io_sel;
  logic [DATA_W-1:0] io_data;
`endif

  modport master (
`ifdef CPU57_SELFTEST_IO_CHECK_EN
    input  io_data,
    output io_sel,
`endif
    input  start, src_data, cpu_halted,
    input  reg_data, exp_data,
    output busy, done, pass, timeout,
    output fail_mask, cycle_count,
    output src_addr, mem_we, mem_addr,
    output mem_wdata, cpu_rst_n,
    output reg_sel, exp_sel
  );

  modport slave (
`ifdef CPU57_SELFTEST_IO_CHECK_EN
    output io_data,
    input  io_sel,
`endif
    output start, src_data, cpu_halted,
    output reg_data, exp_data,
    input  busy, done, pass, timeout,
    input  fail_mask, cycle_count,
    input  src_addr, mem_we, mem_addr,
    input  mem_wdata, cpu_rst_n,
    input  reg_sel, exp_sel
  );
endinterface

// File: rtl/cpu57_selftest_seq.sv
// Self-test sequencer: load program, run cpu57, drain, compare registers.
// CPU57_SELFTEST_IO_CHECK_EN adds an io readback compare into fail_mask[15].
module cpu57_selftest_seq #(
  parameter int DATA_W       = 57,
  parameter int ADDR_W       = 16,
  parameter int PROG_LEN     = 80,
  parameter int NUM_CHECK    = 5,
  parameter int CYCLE_LIMIT  = 200,
  parameter int DRAIN_CYCLES = 5,
  parameter int CNT_W        = 32
`ifdef CPU57_SELFTEST_IO_CHECK_EN
  ,
  parameter int IO_PORT = 5,
  parameter logic [DATA_W-1:0] EXP_IO = DATA_W'(190)
`endif
) (
  input logic clk,
  input logic rst_n,
  cpu57_selftest_seq_if.master bus
);

`ifdef CPU57_SELFTEST_IO_CHECK_EN
  localparam int IOX = 1;
`else
  localparam int IOX = 0;
`endif
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_W:0]   LOAD_LAST = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W-1:0] SRC_LAST = ADDR_W'(PROG_LEN - 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(CYCLE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [4:0]        CHK_END = 5'(NUM_CHECK + IOX);
  localparam logic [4:0]        REG_END = 5'(NUM_CHECK);
  localparam logic [3:0]        SEL_LAST = 4'(NUM_CHECK - 1);
  localparam logic [15:0] CHK_MASK =
    16'((32'd1 << NUM_CHECK) - 32'd1);
`ifdef CPU57_SELFTEST_IO_CHECK_EN
  localparam logic [15:0] VALID_MASK = CHK_MASK | 16'h8000;
`else
  localparam logic [15:0] VALID_MASK = CHK_MASK & 16'h7fff;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_CHECK, S_DONE
  } state_t;

  state_t            state_q;
  logic              cpu_rst_q, busy_q, done_q, pass_q;
  logic              timeout_q, halt_seen_q, mem_we_q;
  logic [15:0]       fail_q, fail_d;
  logic [CNT_W-1:0]  cycle_q, cnt_inc;
  logic [ADDR_W-1:0] src_q, mem_addr_q;
  logic [ADDR_W:0]   load_q;
  logic [DW-1:0]     drain_q;
  logic [4:0]        chk_q;
  logic [3:0]        reg_sel_q, exp_sel_q, idx;
  logic [DATA_W-1:0] rd_q;
  logic              run_exit;

  assign cnt_inc  = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + 1'b1;
  assign run_exit = bus.cpu_halted || (cnt_inc >= LIMIT);
  assign idx      = 4'(chk_q - 5'd1);

  // Register i is sampled into rd_q at CHECK step i, judged at step i+1.
  always_comb begin
    fail_d = fail_q;
    if (state_q == S_CHECK && chk_q != 5'd0) begin
      if (chk_q <= REG_END) begin
        if (rd_q != bus.exp_data) fail_d[idx] = 1'b1;
      end
`ifdef CPU57_SELFTEST_IO_CHECK_EN
      else if (bus.io_data != EXP_IO) begin
        fail_d[15] = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cpu_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      halt_seen_q <= 1'b0;
      mem_we_q    <= 1'b0;
      fail_q      <= '0;
      cycle_q     <= '0;
      src_q       <= '0;
      mem_addr_q  <= '0;
      load_q      <= '0;
      drain_q     <= '0;
      chk_q       <= '0;
      reg_sel_q   <= '0;
      exp_sel_q   <= '0;
      rd_q        <= '0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q     <= S_LOAD;
            cpu_rst_q   <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            halt_seen_q <= 1'b0;
            fail_q      <= '0;
            cycle_q     <= '0;
            src_q       <= '0;
            load_q      <= '0;
          end
        end
        S_LOAD: begin
          mem_we_q   <= (load_q != LOAD_LAST);
          mem_addr_q <= src_q;
          load_q     <= load_q + 1'b1;
          if (src_q != SRC_LAST) src_q <= src_q + 1'b1;
          if (load_q == LOAD_LAST) begin
            state_q   <= S_RUN;
            cpu_rst_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (!bus.cpu_halted) cycle_q <= cnt_inc;
          if (bus.cpu_halted) halt_seen_q <= 1'b1;
          else if (cnt_inc >= LIMIT) timeout_q <= 1'b1;
          if (run_exit) begin
            if (DRAIN_CYCLES == 0) state_q <= S_CHECK;
            else state_q <= S_DRAIN;
            drain_q   <= '0;
            chk_q     <= '0;
            reg_sel_q <= '0;
            exp_sel_q <= '0;
          end
        end
        S_DRAIN: begin
          drain_q <= drain_q + 1'b1;
          if (drain_q == DRAIN_LAST) state_q <= S_CHECK;
        end
        S_CHECK: begin
          rd_q   <= bus.reg_data;
          fail_q <= fail_d;
          chk_q  <= chk_q + 1'b1;
          if (reg_sel_q != SEL_LAST) begin
            reg_sel_q <= reg_sel_q + 1'b1;
            exp_sel_q <= exp_sel_q + 1'b1;
          end
          if (chk_q == CHK_END) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= halt_seen_q && !timeout_q &&
                       ((fail_d & VALID_MASK) == 16'h0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.timeout     = timeout_q;
  assign bus.fail_mask   = fail_q & VALID_MASK;
  assign bus.cycle_count = cycle_q;
  assign bus.src_addr    = src_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_we_q ? bus.src_data : 8'h00;
  assign bus.cpu_rst_n   = cpu_rst_q;
  assign bus.reg_sel     = reg_sel_q;
  assign bus.exp_sel     = exp_sel_q;
`ifdef CPU57_SELFTEST_IO_CHECK_EN
  assign bus.io_sel      = 4'(IO_PORT);
`endif

endmodule

// File: tb/tb_cpu57_selftest_seq.sv
// Bench for cpu57_selftest_seq: two configurations against a cycle-level
// environment (ROM, memory, abstract CPU with a halt latency) and a run model.
module tb_cpu57_selftest_seq;

`ifdef CPU57_SELFTEST_IO_CHECK_EN
  localparam int IOX = 1;
`else
  localparam int IOX = 0;
`endif
  localparam int PL[2]  = '{80, 1};
  localparam int LIM[2] = '{200, 50};
  localparam int DR[2]  = '{5, 0};
  localparam int NCHK   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu57_selftest_seq_if b0 ();
  cpu57_selftest_seq_if b1 ();

  cpu57_selftest_seq u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  cpu57_selftest_seq #(
    .PROG_LEN(1), .DRAIN_CYCLES(0), .CYCLE_LIMIT(50)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  logic [7:0]  rom [2][0:127];
  logic [7:0]  mem [2][0:127];
  logic [56:0] regs [2][0:15];
  logic [56:0] expt [2][0:15];
  int          lat [2];
  int          age [2] = '{0, 0};
  logic        start_r [2] = '{1'b0, 1'b0};
  int          wr [2], aerr [2], busyc [2], hold [2];
  int          ncmp = 0, nerr = 0;

  logic        done_w [2], pass_w [2], to_w [2];
  logic        busy_w [2], crst_w [2];
  logic [15:0] fm_w [2];
  logic [31:0] cc_w [2];

  assign b0.start = start_r[0];
  assign b1.start = start_r[1];
`ifdef CPU57_SELFTEST_IO_CHECK_EN
  assign b0.io_data = 57'd190;
  assign b1.io_data = 57'd190;
`endif

  // Environment of instance 0
  always @(posedge clk) b0.src_data <= rom[0][b0.src_addr[6:0]];
  always @(posedge clk) b0.exp_data <= expt[0][b0.exp_sel];
  always @(posedge clk) age[0] <= b0.cpu_rst_n ? age[0] + 1 : 0;
  assign b0.cpu_halted = b0.cpu_rst_n && (age[0] >= lat[0]);
  assign b0.reg_data = regs[0][b0.reg_sel];
  always @(posedge clk) begin
    if (b0.start && !b0.busy) begin
      wr[0] <= 0; aerr[0] <= 0; busyc[0] <= 0; hold[0] <= 0;
    end else begin
      if (b0.mem_we) begin
        mem[0][b0.mem_addr[6:0]] <= b0.mem_wdata;
        wr[0] <= wr[0] + 1;
        if (b0.mem_addr != 16'(wr[0])) aerr[0] <= aerr[0] + 1;
      end
      if (b0.busy) busyc[0] <= busyc[0] + 1;
      if (b0.busy && !b0.cpu_rst_n) hold[0] <= hold[0] + 1;
    end
  end

  // Environment of instance 1
  always @(posedge clk) b1.src_data <= rom[1][b1.src_addr[6:0]];
  always @(posedge clk) b1.exp_data <= expt[1][b1.exp_sel];
  always @(posedge clk) age[1] <= b1.cpu_rst_n ? age[1] + 1 : 0;
  assign b1.cpu_halted = b1.cpu_rst_n && (age[1] >= lat[1]);
  assign b1.reg_data = regs[1][b1.reg_sel];
  always @(posedge clk) begin
    if (b1.start && !b1.busy) begin
      wr[1] <= 0; aerr[1] <= 0; busyc[1] <= 0; hold[1] <= 0;
    end else begin
      if (b1.mem_we) begin
        mem[1][b1.mem_addr[6:0]] <= b1.mem_wdata;
        wr[1] <= wr[1] + 1;
        if (b1.mem_addr != 16'(wr[1])) aerr[1] <= aerr[1] + 1;
      end
      if (b1.busy) busyc[1] <= busyc[1] + 1;
      if (b1.busy && !b1.cpu_rst_n) hold[1] <= hold[1] + 1;
    end
  end

  assign done_w[0] = b0.done;      assign done_w[1] = b1.done;
  assign pass_w[0] = b0.pass;      assign pass_w[1] = b1.pass;
  assign to_w[0]   = b0.timeout;   assign to_w[1]   = b1.timeout;
  assign busy_w[0] = b0.busy;      assign busy_w[1] = b1.busy;
  assign crst_w[0] = b0.cpu_rst_n; assign crst_w[1] = b1.cpu_rst_n;
  assign fm_w[0]   = b0.fail_mask; assign fm_w[1]   = b1.fail_mask;
  assign cc_w[0]   = b0.cycle_count;
  assign cc_w[1]   = b1.cycle_count;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int k, input bit flip);
    for (int i = 0; i < PL[k]; i++) rom[k][i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      regs[k][i] = 57'({$urandom(), $urandom()});
      expt[k][i] = regs[k][i];
      if (flip && $urandom_range(0, 2) == 0)
        expt[k][i] = regs[k][i] ^ (57'd1 << $urandom_range(0, 56));
    end
  endtask

  // Start instance k, wait for DONE and compare against the run model.
  task automatic run(input int k, input string tag, input int l,
                     input bit poke);
    int n, memerr, exprun, expc;
    bit expto;
    logic [15:0] expm;
    expto = (l >= LIM[k]);
    expc = expto ? LIM[k] : l;
    exprun = expto ? LIM[k] : l + 1;
    expm = '0;
    for (int i = 0; i < NCHK; i++)
      if (regs[k][i] !== expt[k][i]) expm[i] = 1'b1;
    lat[k] = l;
    @(negedge clk); start_r[k] = 1'b1;
    @(negedge clk); start_r[k] = 1'b0;
    n = 0;
    while (!done_w[k] && n < 3000) begin
      @(negedge clk);
      n++;
      start_r[k] = poke && (n == 20);
    end
    start_r[k] = 1'b0;
    chk({tag, ":done"}, 64'(done_w[k]), 64'd1);
    chk({tag, ":busy_cycles"}, 64'(busyc[k]),
        64'(PL[k] + 1 + exprun + DR[k] + NCHK + 1 + IOX));
    chk({tag, ":cpu_held"}, 64'(hold[k]), 64'(PL[k] + 1));
    chk({tag, ":writes"}, 64'(wr[k]), 64'(PL[k]));
    chk({tag, ":addr_order"}, 64'(aerr[k]), 64'd0);
    memerr = 0;
    for (int i = 0; i < PL[k]; i++)
      if (mem[k][i] !== rom[k][i]) memerr++;
    chk({tag, ":mem_image"}, 64'(memerr), 64'd0);
    chk({tag, ":cycle_count"}, 64'(cc_w[k]), 64'(expc));
    chk({tag, ":timeout"}, 64'(to_w[k]), 64'(expto));
    chk({tag, ":fail_mask"}, 64'(fm_w[k]), 64'(expm));
    chk({tag, ":pass"}, 64'(pass_w[k]), 64'(!expto && expm == 0));
    chk({tag, ":busy"}, 64'(busy_w[k]), 64'd0);
    chk({tag, ":cpu_rst_n"}, 64'(crst_w[k]), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [56:0] res [5];
    res = '{57'd95, 57'd5, 57'd190, 57'd2, 57'd1000};
    lat = '{1000000, 1000000};
    fill(0, 0);
    fill(1, 0);

    // Reset and idle
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst:busy", 64'(b0.busy), 64'd0);
    chk("rst:done", 64'(b0.done), 64'd0);
    chk("rst:pass", 64'(b0.pass), 64'd0);
    chk("rst:timeout", 64'(b0.timeout), 64'd0);
    chk("rst:fail_mask", 64'(b0.fail_mask), 64'd0);
    chk("rst:cycle_count", 64'(b0.cycle_count), 64'd0);
    chk("rst:src_addr", 64'(b0.src_addr), 64'd0);
    chk("rst:mem_we", 64'(b0.mem_we), 64'd0);
    chk("rst:mem_addr", 64'(b0.mem_addr), 64'd0);
    chk("rst:mem_wdata", 64'(b0.mem_wdata), 64'd0);
    chk("rst:reg_sel", 64'(b0.reg_sel), 64'd0);
    chk("rst:exp_sel", 64'(b0.exp_sel), 64'd0);
    chk("rst:cpu_rst_n", 64'(b0.cpu_rst_n), 64'd0);
    chk("rst:b1_busy", 64'(b1.busy), 64'd0);

    // Nominal arithmetic program
    fill(0, 0);
    rom[0][54] = 8'hE8;
    for (int i = 0; i < 5; i++) begin
      regs[0][i] = res[i];
      expt[0][i] = res[i];
    end
    run(0, "nominal", 60, 1'b0);
    chk("nominal:mem54", 64'(mem[0][54]), 64'hE8);

    // Mismatch in entry 2
    expt[0][2] = 57'd191;
    run(0, "mismatch", 60, 1'b0);
    chk("mismatch:mask", 64'(b0.fail_mask), 64'h0004);

    // Timeout on the short-limit instance
    fill(1, 0);
    rom[1][0] = 8'h40;
    run(1, "timeout", 1000000, 1'b0);
    chk("timeout:count50", 64'(b1.cycle_count), 64'd50);

    // Boundary: single byte, no drain, halt latency edges
    fill(1, 0);
    rom[1][0] = 8'hFF;
    run(1, "bound_l3", 3, 1'b0);
    run(1, "bound_l0", 0, 1'b0);
    run(1, "bound_l49", 49, 1'b0);
    run(1, "bound_l50", 50, 1'b0);

    // Reset during RUN, then restart
    fill(0, 0);
    lat[0] = 60;
    @(negedge clk); start_r[0] = 1'b1;
    @(negedge clk); start_r[0] = 1'b0;
    n = 0;
    while (b0.cycle_count != 32'd10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midrst:reach_run10", 64'(b0.cycle_count), 64'd10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst:cpu_rst_n", 64'(b0.cpu_rst_n), 64'd0);
    chk("midrst:busy", 64'(b0.busy), 64'd0);
    chk("midrst:cycle_count", 64'(b0.cycle_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, "restart", 40, 1'b0);
    chk("restart:pass", 64'(b0.pass), 64'd1);

    // Randomized runs, some with a start pulse mid-operation
    for (int r = 0; r < 6; r++) begin
      fill(0, 1);
      run(0, $sformatf("rand0_%0d", r), $urandom_range(0, 260), r[0]);
    end
    for (int r = 0; r < 4; r++) begin
      fill(1, 1);
      run(1, $sformatf("rand1_%0d", r), $urandom_range(0, 70), r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
